// File: rtl/lfsr_pkg.sv
// lfsr_pkg: constants and helpers shared by the PRBS generator and checker.
//   LFSR_W     register width
//   LFSR_TAPS  feedback tap mask (bit i set = tap i)
//   LFSR_SEED  generator seed
//   state_t    checker states
//   lfsr_fb()  feedback bit: XOR of the tapped history bits
package lfsr_pkg;
   localparam int             LFSR_W    = 8;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0101_0101;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h49;

   typedef enum logic [1:0] {FILL, HUNT, LOCKED} state_t;

   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] hist);
      return ^(hist & LFSR_TAPS);
   endfunction
endpackage

// File: rtl/lfsr_predictor.sv
// lfsr_predictor: history shift register plus next-bit prediction.
//   clk, reset  clock, async active-high reset (hist -> 0)
//   shift_en    shift shift_in into hist this edge
//   shift_in    bit entering hist at the top (hist[0] is the oldest)
//   in_bit      received bit compared against the prediction
//   hist        current history
//   pred        predicted next bit from the recurrence
//   match       in_bit equals pred
module lfsr_predictor
   import lfsr_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en,
   input  logic              shift_in,
   input  logic              in_bit,
   output logic [LFSR_W-1:0] hist,
   output logic              pred,
   output logic              match
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         hist <= '0;
      else if (shift_en)
         hist <= {shift_in, hist[LFSR_W-1:1]};
   end

   assign pred  = lfsr_fb(hist);
   assign match = (in_bit == pred);

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising PRBS checker with lock detection and a
// saturating error counter.
//   clk, reset  clock, async active-high reset
//   in_valid    in_bit is accepted on this edge
//   in_bit      received serial bit
//   clear_err   synchronous clear of err_count
//   locked      checker is in LOCKED
//   err_pulse   previous accepted bit mismatched while LOCKED
//   err_count   saturating mismatch count while LOCKED
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4,
   parameter int ERR_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear_err,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
   localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

   state_t            state;
   logic [2:0]        fill_cnt;
   logic [7:0]        match_cnt;
   logic [3:0]        miss_cnt;
   logic [LFSR_W-1:0] hist;
   logic              pred, match, shift_in, err_hit;
   logic [ERR_W-1:0]  cnt_base, cnt_next;

   // Once locked, the history free-runs on its own prediction so a single
   // corrupted bit produces exactly one error instead of a burst.
   assign shift_in = (state == LOCKED) ? pred : in_bit;
   assign err_hit  = in_valid && (state == LOCKED) && !match;

   lfsr_predictor u_pred (
      .clk      (clk),
      .reset    (reset),
      .shift_en (in_valid),
      .shift_in (shift_in),
      .in_bit   (in_bit),
      .hist     (hist),
      .pred     (pred),
      .match    (match)
   );

   // Clear takes effect first, so a coincident error leaves the count at 1.
   always_comb begin
      cnt_base = clear_err ? '0 : err_count;
      cnt_next = cnt_base;
      if (err_hit && (cnt_base != '1))
         cnt_next = cnt_base + ERR_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FILL;
         fill_cnt  <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= err_hit;
         err_count <= cnt_next;
         if (in_valid) begin
            case (state)
               FILL: begin
                  fill_cnt <= fill_cnt + 3'd1;
                  if (fill_cnt == 3'd7) begin
                     state     <= HUNT;
                     match_cnt <= '0;
                  end
               end
               HUNT: begin
                  // An all-zero history trivially predicts zeros; never lock on it.
                  if (match && (hist != '0)) begin
                     if (match_cnt == LOCK_LAST) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        miss_cnt  <= '0;
                        match_cnt <= '0;
                     end else begin
                        match_cnt <= match_cnt + 8'd1;
                     end
                  end else begin
                     match_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (!match) begin
                     if (miss_cnt == UNLOCK_LAST) begin
                        state    <= FILL;
                        fill_cnt <= '0;
                        locked   <= 1'b0;
                        miss_cnt <= '0;
                     end else begin
                        miss_cnt <= miss_cnt + 4'd1;
                     end
                  end else begin
                     miss_cnt <= '0;
                  end
               end
               default: state <= FILL;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed checks of lfsr_checker. A table of checkpoints
// (scenario, bit index, expected outputs) is applied over generated streams;
// hand-written sequences cover idle beats, async reset and clear_err.
module tb_lfsr_checker;
   import lfsr_pkg::*;

   logic       clk = 1'b0;
   logic       reset, in_valid, in_bit, clear_err;
   logic       locked, err_pulse, locked4, err_pulse4;
   logic [15:0] err_count;
   logic [3:0]  err_count4;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] gen;

   always #5 clk = ~clk;

   lfsr_checker #(.LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
      .clear_err(clear_err), .locked(locked), .err_pulse(err_pulse),
      .err_count(err_count)
   );

   // Narrow counter copy sharing the same stimulus, for saturation.
   lfsr_checker #(.LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_W(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
      .clear_err(clear_err), .locked(locked4), .err_pulse(err_pulse4),
      .err_count(err_count4)
   );

   typedef struct {
      int   scen;
      int   idx;
      logic lk;
      logic pl;
      int   cnt;
      int   sat;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int s, input int i, input logic lk, input logic pl,
                      input int c, input int sc);
      vec_t v;
      v.scen = s; v.idx = i; v.lk = lk; v.pl = pl; v.cnt = c; v.sat = sc;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic gen_next(output logic b);
      b   = gen[0];
      gen = {lfsr_fb(gen), gen[7:1]};
   endtask

   task automatic send(input logic v, input logic b, input logic clr);
      in_valid  = v;
      in_bit    = b;
      clear_err = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_err = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      gen   = LFSR_SEED;
   endtask

   function automatic logic inv_of(input int s, input int n);
      case (s)
         1:       return (n == 40) || (n >= 60 && n <= 63);
         3:       return (n >= 30) && (n <= 68) && (n % 2 == 0);
         default: return 1'b0;
      endcase
   endfunction

   int   scen_len [4] = '{200, 121, 100, 70};
   logic b;
   logic saw_pulse;

   initial begin
      // scenario 0: clean stream
      add(0,  22, 0, 0, 0, 0);  add(0,  23, 1, 0, 0, 0);  add(0, 199, 1, 0, 0, 0);
      // scenario 1: isolated error at 40, burst 60..63 -> unlock, relock at 87
      add(1,  39, 1, 0, 0, 0);  add(1,  40, 1, 1, 1, 1);  add(1,  41, 1, 0, 1, 1);
      add(1,  62, 1, 1, 4, 4);  add(1,  63, 0, 1, 5, 5);  add(1,  64, 0, 0, 5, 5);
      add(1,  86, 0, 0, 5, 5);  add(1,  87, 1, 0, 5, 5);  add(1, 120, 1, 0, 5, 5);
      // scenario 2: constant zero never locks
      add(2,  23, 0, 0, 0, 0);  add(2,  99, 0, 0, 0, 0);
      // scenario 3: 20 isolated errors, narrow counter saturates at 15
      add(3,  30, 1, 1, 1, 1);  add(3,  49, 1, 0, 10, 10);
      add(3,  68, 1, 1, 20, 15); add(3,  69, 1, 0, 20, 15);

      do_reset();
      chk("rst_locked", int'(locked), 0);
      chk("rst_pulse",  int'(err_pulse), 0);
      chk("rst_count",  int'(err_count), 0);

      for (int s = 0; s < 4; s++) begin
         do_reset();
         saw_pulse = 1'b0;
         for (int n = 0; n < scen_len[s]; n++) begin
            gen_next(b);
            if (s == 2) b = 1'b0;
            send(1'b1, b ^ inv_of(s, n), 1'b0);
            if (err_pulse) saw_pulse = 1'b1;
            foreach (tbl[k]) begin
               if (tbl[k].scen == s && tbl[k].idx == n) begin
                  chk($sformatf("s%0d_b%0d_locked", s, n), int'(locked), int'(tbl[k].lk));
                  chk($sformatf("s%0d_b%0d_pulse", s, n),  int'(err_pulse), int'(tbl[k].pl));
                  chk($sformatf("s%0d_b%0d_count", s, n),  int'(err_count), tbl[k].cnt);
                  chk($sformatf("s%0d_b%0d_sat", s, n),    int'(err_count4), tbl[k].sat);
               end
            end
         end
         if (s == 0 || s == 2) chk($sformatf("s%0d_no_pulse", s), int'(saw_pulse), 0);
      end

      // in_valid toggling; idle beats carry the inverted bit and must be ignored
      do_reset();
      for (int k = 0; k < 24; k++) begin
         gen_next(b);
         send(1'b1, b, 1'b0);
         if (k == 22) chk("tog_locked_23", int'(locked), 0);
         if (k == 23) chk("tog_locked_24", int'(locked), 1);
         send(1'b0, ~gen[0], 1'b0);
         if (k == 23) begin
            chk("tog_idle_locked", int'(locked), 1);
            chk("tog_idle_pulse",  int'(err_pulse), 0);
            chk("tog_idle_count",  int'(err_count), 0);
         end
      end
      for (int k = 0; k < 4; k++) begin
         gen_next(b);
         send(1'b1, b, 1'b0);
         send(1'b0, ~gen[0], 1'b0);
      end
      chk("tog_end_count", int'(err_count), 0);

      // async reset mid-stream, after errors at 40 and 49
      do_reset();
      for (int n = 0; n < 50; n++) begin
         gen_next(b);
         send(1'b1, b ^ (n == 40 || n == 49), 1'b0);
      end
      chk("pre_rst_pulse", int'(err_pulse), 1);
      chk("pre_rst_count", int'(err_count), 2);
      reset = 1'b1;
      #1;
      chk("async_rst_locked", int'(locked), 0);
      chk("async_rst_pulse",  int'(err_pulse), 0);
      chk("async_rst_count",  int'(err_count), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // clear_err coincident with an error, then clear alone
      do_reset();
      for (int n = 0; n < 35; n++) begin
         gen_next(b);
         send(1'b1, b ^ (n == 30), 1'b0);
      end
      chk("clr_pre_count", int'(err_count), 1);
      gen_next(b);
      send(1'b1, ~b, 1'b1);
      chk("clr_err_count", int'(err_count), 1);
      chk("clr_err_pulse", int'(err_pulse), 1);
      gen_next(b);
      send(1'b1, b, 1'b1);
      chk("clr_only_count",  int'(err_count), 0);
      chk("clr_only_locked", int'(locked), 1);
      gen_next(b);
      send(1'b1, b, 1'b0);
      chk("clr_after_count", int'(err_count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Serial PRBS checker; the receive end of the 8-bit right-shift LFSR generator (taps 0,2,4,6; serial output = register bit 0 each step).
- Self-synchronises to the incoming bit stream, declares lock, then free-runs its own prediction to count bit errors.
- Sits at the link/BIST sink, fed one bit per in_valid beat.
- Recurrence checked: s[n+8] = s[n] ^ s[n+2] ^ s[n+4] ^ s[n+6].

Parameters:
- LOCK_CNT, 16: consecutive matching bits in HUNT required to enter LOCKED (range 1..255).
- UNLOCK_CNT, 4: consecutive mismatching bits in LOCKED that force loss of lock (range 1..15).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_bit is sampled on this edge.
- in_bit  input  1  received serial bit.
- clear_err  input  1  synchronous clear of err_count.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle pulse: the previously accepted bit mismatched while LOCKED.
- err_count  output  ERR_W  saturating count of mismatches seen while LOCKED.

Behaviour:
- Reset (async, active-high) forces the following; reset mid-operation aborts everything immediately:
  - state=FILL, hist=8'h00, fill/match/miss counters=0.
  - locked=0, err_pulse=0, err_count=0.
- All outputs are registered and reflect the bit accepted on the preceding edge. With in_valid=0, state/hist/counters hold and err_pulse=0.
- hist is an 8-bit shift register: hist <= {b, hist[7:1]}, where hist[0] is the oldest bit. pred = hist[0]^hist[2]^hist[4]^hist[6]. match = (in_bit == pred).
- FILL:
  - Each valid bit: b=in_bit, fill_cnt++.
  - After the 8th valid bit, go to HUNT with match_cnt=0.
- HUNT:
  - Each valid bit: b=in_bit (self-sync).
  - If match and hist != 0: match_cnt++.
  - Otherwise match_cnt=0. The all-zero history never qualifies for lock.
  - When the bit making match_cnt reach LOCK_CNT is accepted: state=LOCKED and locked=1 after that edge.
- LOCKED:
  - Each valid bit: b=pred (free-run), so isolated errors do not propagate.
  - On mismatch: err_pulse=1 next cycle, err_count++ (saturates at all-ones, no wrap), miss_cnt++.
  - On match: miss_cnt=0.
  - When miss_cnt reaches UNLOCK_CNT: state=FILL, fill_cnt=0, locked=0 after that edge. The UNLOCK_CNT errors are all counted.
- Errors are never counted in FILL or HUNT.
- clear_err with a coincident LOCKED mismatch: the counter becomes 1. Clear first, then count the new error.
- clear_err alone: err_count=0 next edge; state and lock are unaffected.
- Earliest lock: 8+LOCK_CNT valid bits after reset (24 at defaults).

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_W=8.
  - LFSR_TAPS=8'b0101_0101 (tap mask, bit i set = tap i).
  - LFSR_SEED=8'h49.
  - State enum {FILL, HUNT, LOCKED}.
  - A function lfsr_fb(hist) returning the XOR of masked bits, shared with the generator.
- One natural sub-module: lfsr_predictor. It holds hist, applies the shift, and produces pred/match. The FSM and counters stay in lfsr_checker.

Test Plan:
- Generator (seed 8'h49) drives in_valid=1 continuously from bit 0:
  - locked rises after the 24th bit edge.
  - err_pulse stays 0 and err_count=0 for 200 bits.
- Same stream with bit 40 inverted:
  - err_pulse high for exactly one cycle after bit 40.
  - err_count=1, locked stays 1.
  - No further errors (free-run prediction).
- Bits 60..63 inverted (4 consecutive):
  - err_count increments by 4.
  - locked falls after bit 63.
  - Relocks 24 clean bits later, i.e. after bit 87.
- Constant in_bit=0 for 100 bits: locked never asserts, err_count=0.
- With in_valid toggling 1/0 every cycle on the clean stream:
  - locked after 24 valid beats (48 clocks).
  - Held values are unchanged on idle cycles.
- Corner cases on a locked stream:
  - Async reset at bit 50: all outputs 0 immediately.
  - clear_err coincident with a forced error: err_count=1.
  - ERR_W=4 with 20 errors: err_count saturates at 15.
